// File: rtl/hazard_sequencer.sv
// Pipeline scheduler for the 4-stage 8-bit RISC core.
// Decides every cycle whether stages 1-3 advance, hold, take a bubble or are
// flushed, and arbitrates the single memory port between instruction fetch
// (stage 1) and data access (stage 4). Every output is a registered decode of
// the next state, so it changes on the same edge as the state register.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       id_valid_i,
  input  logic       id_src_r0_i,
  input  logic       id_src_rn_i,
  input  logic [2:0] id_rn_i,
  input  logic       ex_valid_i,
  input  logic       ex_wr_r0_i,
  input  logic       ex_wr_rn_i,
  input  logic [2:0] ex_rn_i,
  input  logic       lpc_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       hold_if_o,
  output logic       hold_id_o,
  output logic       hold_ex_o,
  output logic       bubble_ex_o,
  output logic       flush_if_o,
  output logic       flush_id_o,
  output logic       imem_grant_o,
  output logic       dmem_grant_o,
  output logic       err_timeout_o,
  output logic [7:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    Run,
    RawStall,
    MemWait,
    Flush
  } state_e;

  // Limits brought to the counter width once so the compares stay 8-bit.
  localparam logic [7:0] FlushLimit = 8'(FLUSH_CYCLES);
  localparam logic [7:0] MemLimit   = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       flushPending_q, flushPending_d;
  logic       errTimeout_q, errTimeout_d;
  logic [7:0] stallCnt_q, stallCnt_d;

  logic       holdIf_q, holdIf_d;
  logic       holdId_q, holdId_d;
  logic       holdEx_q, holdEx_d;
  logic       bubbleEx_q, bubbleEx_d;
  logic       flushIf_q, flushIf_d;
  logic       flushId_q, flushId_d;
  logic       imemGrant_q, imemGrant_d;
  logic       dmemGrant_q, dmemGrant_d;

  logic       rawHit;
  logic [7:0] cntInc;
  logic       memTimeout;
  logic       flushDone;

  // Read-after-write hazard between the instruction in decode and the one in execute.
  assign rawHit = id_valid_i & ex_valid_i &
                  ((id_src_r0_i & ex_wr_r0_i) |
                   (id_src_rn_i & ex_wr_rn_i & (id_rn_i == ex_rn_i)));

  // cnt counts cycles already spent in the current state, so the cycle being
  // completed is the cntInc-th one.
  assign cntInc     = cnt_q + 8'd1;
  assign memTimeout = (cntInc == MemLimit);
  assign flushDone  = (cntInc == FlushLimit);

  // Next-state logic: the older stage wins (memory access, then branch, then RAW).
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flushPending_d = flushPending_q;
    errTimeout_d   = errTimeout_q;
    unique case (state_q)
      Run, RawStall: begin
        if (dmem_req_i) begin
          state_d        = MemWait;
          cnt_d          = 8'd0;
          flushPending_d = lpc_i;
        end else if (lpc_i) begin
          state_d = Flush;
          cnt_d   = 8'd0;
        end else if (rawHit) begin
          state_d = RawStall;
        end else begin
          state_d = Run;
        end
      end
      MemWait: begin
        cnt_d = cntInc;
        if (lpc_i) begin
          flushPending_d = 1'b1;
        end
        if (dmem_ack_i || memTimeout) begin
          if (!dmem_ack_i) begin
            errTimeout_d = 1'b1;
          end
          cnt_d          = 8'd0;
          flushPending_d = 1'b0;
          if (flushPending_q || lpc_i) begin
            state_d = Flush;
          end else begin
            state_d = Run;
          end
        end
      end
      Flush: begin
        if (dmem_req_i) begin
          state_d        = MemWait;
          cnt_d          = 8'd0;
          flushPending_d = 1'b1;
        end else if (lpc_i) begin
          cnt_d = 8'd0;
        end else if (flushDone) begin
          state_d = Run;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cntInc;
        end
      end
      default: begin
        state_d        = Run;
        cnt_d          = 8'd0;
        flushPending_d = 1'b0;
      end
    endcase
  end

  // Saturating count of cycles spent in the RAW stall, counted as each one begins.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if ((state_d == RawStall) && (stallCnt_q != 8'hFF)) begin
      stallCnt_d = stallCnt_q + 8'd1;
    end
  end

  // Moore decode of the next state feeding the output registers.
  always_comb begin
    holdIf_d    = 1'b0;
    holdId_d    = 1'b0;
    holdEx_d    = 1'b0;
    bubbleEx_d  = 1'b0;
    flushIf_d   = 1'b0;
    flushId_d   = 1'b0;
    imemGrant_d = 1'b1;
    dmemGrant_d = 1'b0;
    unique case (state_d)
      Run: begin
        imemGrant_d = 1'b1;
      end
      RawStall: begin
        holdIf_d   = 1'b1;
        holdId_d   = 1'b1;
        bubbleEx_d = 1'b1;
      end
      MemWait: begin
        holdIf_d    = 1'b1;
        holdId_d    = 1'b1;
        holdEx_d    = 1'b1;
        imemGrant_d = 1'b0;
        dmemGrant_d = 1'b1;
      end
      Flush: begin
        flushIf_d  = 1'b1;
        flushId_d  = 1'b1;
        bubbleEx_d = 1'b1;
      end
      default: begin
        imemGrant_d = 1'b1;
      end
    endcase
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q        <= Run;
      cnt_q          <= 8'd0;
      flushPending_q <= 1'b0;
      errTimeout_q   <= 1'b0;
      stallCnt_q     <= 8'd0;
      holdIf_q       <= 1'b0;
      holdId_q       <= 1'b0;
      holdEx_q       <= 1'b0;
      bubbleEx_q     <= 1'b0;
      flushIf_q      <= 1'b0;
      flushId_q      <= 1'b0;
      imemGrant_q    <= 1'b1;
      dmemGrant_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flushPending_q <= flushPending_d;
      errTimeout_q   <= errTimeout_d;
      stallCnt_q     <= stallCnt_d;
      holdIf_q       <= holdIf_d;
      holdId_q       <= holdId_d;
      holdEx_q       <= holdEx_d;
      bubbleEx_q     <= bubbleEx_d;
      flushIf_q      <= flushIf_d;
      flushId_q      <= flushId_d;
      imemGrant_q    <= imemGrant_d;
      dmemGrant_q    <= dmemGrant_d;
    end
  end

  assign hold_if_o     = holdIf_q;
  assign hold_id_o     = holdId_q;
  assign hold_ex_o     = holdEx_q;
  assign bubble_ex_o   = bubbleEx_q;
  assign flush_if_o    = flushIf_q;
  assign flush_id_o    = flushId_q;
  assign imem_grant_o  = imemGrant_q;
  assign dmem_grant_o  = dmemGrant_q;
  assign err_timeout_o = errTimeout_q;
  assign stall_cnt_o   = stallCnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed testbench for hazard_sequencer. A second instance built with
// FLUSH_CYCLES=3 shares the stimulus to cover the longer flush window.
module tb_hazard_sequencer;

  // Output vector layout: hold_if hold_id hold_ex bubble_ex flush_if flush_id imem dmem err
  localparam logic [8:0] ExpRun    = 9'b000000100;
  localparam logic [8:0] ExpRunErr = 9'b000000101;
  localparam logic [8:0] ExpRaw    = 9'b110100100;
  localparam logic [8:0] ExpMem    = 9'b111000010;
  localparam logic [8:0] ExpMemErr = 9'b111000011;
  localparam logic [8:0] ExpFlush  = 9'b000111100;

  logic       clk = 1'b0;
  logic       rstN;
  logic       idValid, idSrcR0, idSrcRn, exValid, exWrR0, exWrRn;
  logic [2:0] idRn, exRn;
  logic       lpc, dmemReq, dmemAck;

  logic       holdIf, holdId, holdEx, bubbleEx, flushIf, flushId, imemGrant, dmemGrant, errTimeout;
  logic [7:0] stallCnt;
  logic       holdIf3, holdId3, holdEx3, bubbleEx3, flushIf3, flushId3, imemGrant3, dmemGrant3, errTimeout3;
  logic [7:0] stallCnt3;

  logic [8:0] outVec, outVec3;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  hazard_sequencer dut (
    .clk_i(clk), .rst_n_i(rstN),
    .id_valid_i(idValid), .id_src_r0_i(idSrcR0), .id_src_rn_i(idSrcRn), .id_rn_i(idRn),
    .ex_valid_i(exValid), .ex_wr_r0_i(exWrR0), .ex_wr_rn_i(exWrRn), .ex_rn_i(exRn),
    .lpc_i(lpc), .dmem_req_i(dmemReq), .dmem_ack_i(dmemAck),
    .hold_if_o(holdIf), .hold_id_o(holdId), .hold_ex_o(holdEx), .bubble_ex_o(bubbleEx),
    .flush_if_o(flushIf), .flush_id_o(flushId), .imem_grant_o(imemGrant),
    .dmem_grant_o(dmemGrant), .err_timeout_o(errTimeout), .stall_cnt_o(stallCnt)
  );

  hazard_sequencer #(.FLUSH_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_n_i(rstN),
    .id_valid_i(idValid), .id_src_r0_i(idSrcR0), .id_src_rn_i(idSrcRn), .id_rn_i(idRn),
    .ex_valid_i(exValid), .ex_wr_r0_i(exWrR0), .ex_wr_rn_i(exWrRn), .ex_rn_i(exRn),
    .lpc_i(lpc), .dmem_req_i(dmemReq), .dmem_ack_i(dmemAck),
    .hold_if_o(holdIf3), .hold_id_o(holdId3), .hold_ex_o(holdEx3), .bubble_ex_o(bubbleEx3),
    .flush_if_o(flushIf3), .flush_id_o(flushId3), .imem_grant_o(imemGrant3),
    .dmem_grant_o(dmemGrant3), .err_timeout_o(errTimeout3), .stall_cnt_o(stallCnt3)
  );

  assign outVec  = {holdIf, holdId, holdEx, bubbleEx, flushIf, flushId, imemGrant, dmemGrant, errTimeout};
  assign outVec3 = {holdIf3, holdId3, holdEx3, bubbleEx3, flushIf3, flushId3, imemGrant3, dmemGrant3, errTimeout3};

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Output vector of the default instance plus the one-owner grant rule.
  task automatic checkState(input string tag, input logic [8:0] expected);
    checkOutput(tag, {23'd0, outVec}, {23'd0, expected});
    checkOutput({tag, "_grant"}, {31'd0, imemGrant ^ dmemGrant}, 32'd1);
  endtask

  // Advance past the next rising edge; outputs are settled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the branch/memory inputs for one sampling edge.
  task automatic applyStimulus(input logic lpcV, input logic reqV, input logic ackV);
    lpc     = lpcV;
    dmemReq = reqV;
    dmemAck = ackV;
    tick();
  endtask

  task automatic clearRaw();
    idValid = 1'b0; idSrcR0 = 1'b0; idSrcRn = 1'b0; idRn = 3'd0;
    exValid = 1'b0; exWrR0  = 1'b0; exWrRn  = 1'b0; exRn = 3'd0;
  endtask

  task automatic doReset();
    clearRaw();
    lpc = 1'b0; dmemReq = 1'b0; dmemAck = 1'b0;
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    doReset();
    checkState("reset_hold", ExpRun);
    checkOutput("reset_stall", {24'd0, stallCnt}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("reset_release", ExpRun);
    checkOutput("reset_release_stall", {24'd0, stallCnt}, 32'd0);

    // RAW hazard on Rn (R3 vs R3) for one sample
    idValid = 1'b1; idSrcRn = 1'b1; idRn = 3'd3;
    exValid = 1'b1; exWrRn = 1'b1; exRn = 3'd3;
    tick();
    clearRaw();
    checkState("raw_rn_stall", ExpRaw);
    tick();
    checkState("raw_rn_after", ExpRun);
    checkOutput("raw_rn_count", {24'd0, stallCnt}, 32'd1);

    // Different register index: no hazard
    idValid = 1'b1; idSrcRn = 1'b1; idRn = 3'd3;
    exValid = 1'b1; exWrRn = 1'b1; exRn = 3'd4;
    tick();
    clearRaw();
    checkState("raw_miss", ExpRun);
    checkOutput("raw_miss_count", {24'd0, stallCnt}, 32'd1);

    // RAW hazard on R0
    idValid = 1'b1; idSrcR0 = 1'b1; exValid = 1'b1; exWrR0 = 1'b1;
    tick();
    clearRaw();
    checkState("raw_r0_stall", ExpRaw);
    checkOutput("raw_r0_count", {24'd0, stallCnt}, 32'd2);
    tick();
    checkState("raw_r0_after", ExpRun);

    // Taken branch: 2-cycle flush, 3 cycles on the FLUSH_CYCLES=3 instance
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("br_c1", ExpFlush);
    checkOutput("br3_c1", {23'd0, outVec3}, {23'd0, ExpFlush});
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("br_c2", ExpFlush);
    checkOutput("br3_c2", {23'd0, outVec3}, {23'd0, ExpFlush});
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("br_c3", ExpRun);
    checkOutput("br3_c3", {23'd0, outVec3}, {23'd0, ExpFlush});
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("br3_c4", {23'd0, outVec3}, {23'd0, ExpRun});

    // Second branch during the flush restarts the window
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("br2_c1", ExpFlush);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("br2_c2", ExpFlush);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("br2_c3", ExpFlush);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("br2_c4", ExpRun);

    // Memory handshake: ack arrives in the fourth wait cycle
    doReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkState($sformatf("mem_c%0d", i), ExpMem);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("mem_done", ExpRun);

    // Simultaneous request and branch: memory first, then a full flush
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("both_mem1", ExpMem);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("both_mem2", ExpMem);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("both_fl1", ExpFlush);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("both_fl2", ExpFlush);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("both_run", ExpRun);

    // Memory request during a flush: flush resumes after the access
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("flmem_fl", ExpFlush);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("flmem_mem", ExpMem);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("flmem_fl1", ExpFlush);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("flmem_fl2", ExpFlush);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("flmem_run", ExpRun);

    // Ack in the 15th wait cycle counts as success
    doReset();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (i == 15) checkState("ack15_c15", ExpMem);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("ack15_done", ExpRun);

    // Timeout: no ack for 15 cycles sets the sticky error
    doReset();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkState($sformatf("tmo_c%0d", i), ExpMem);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("tmo_exit", ExpRunErr);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("tmo_sticky", ExpRunErr);

    // Reset in the middle of a new wait clears everything at once
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("mid_mem", ExpMemErr);
    applyStimulus(1'b0, 1'b1, 1'b0);
    rstN = 1'b0;
    tick();
    checkState("mid_reset", ExpRun);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("mid_reset_after", ExpRun);

    // Stall counter saturates at 255 under a persistent hazard
    doReset();
    idValid = 1'b1; idSrcRn = 1'b1; idRn = 3'd5;
    exValid = 1'b1; exWrRn = 1'b1; exRn = 3'd5;
    for (int i = 0; i < 260; i++) tick();
    checkState("sat_stall", ExpRaw);
    checkOutput("sat_count", {24'd0, stallCnt}, 32'd255);
    clearRaw();
    tick();
    checkState("sat_release", ExpRun);
    checkOutput("sat_hold", {24'd0, stallCnt}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
